// File: rtl/logic_unit_pipe.sv
// Purpose: registered bitwise logic unit (8 ops) with optional accumulate mode.
// Latency: 1 cycle from accepted input to out_valid/out_data.
// Backpressure: single output register, in_ready = ~out_valid | out_ready (no skid).
//
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   in_valid/in_ready             input handshake; in_a, in_b, in_op, in_acc sampled on accept
//   acc_clr                       reload accumulator with ACC_INIT (also forces it as operand A)
//   out_valid/out_ready           output handshake
//   out_data, out_zero, out_parity registered result and its flags
//   acc_value                     accumulator register contents
module logic_unit_pipe #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_value
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Result register contents kept together so they always update as one.
  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             zero;
    logic             parity;
  } res_t;

  res_t             res_q;
  res_t             res_d;
  logic             vld_q;
  logic [WIDTH-1:0] acc_q;

  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;

  // Only one result slot: we can take new input when it is empty or draining now.
  assign in_ready = ~vld_q | out_ready;
  assign accept   = in_valid & in_ready;

  // A same-cycle clear makes the operation see ACC_INIT rather than the stale value.
  assign acc_eff  = acc_clr ? ACC_INIT : acc_q;
  assign op_a     = in_acc ? acc_eff : in_a;

  always_comb begin
    result = '0;
    unique case (op_e'(in_op))
      OP_NOT:  result = ~op_a;
      OP_AND:  result = op_a & in_b;
      OP_OR:   result = op_a | in_b;
      OP_NAND: result = ~(op_a & in_b);
      OP_NOR:  result = ~(op_a | in_b);
      OP_XOR:  result = op_a ^ in_b;
      OP_XNOR: result = ~(op_a ^ in_b);
      OP_PASS: result = op_a;
      default: result = '0;
    endcase
  end

  always_comb begin
    res_d        = '0;
    res_d.dat    = result;
    res_d.zero   = (result == '0);
    res_d.parity = ^result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= 1'b0;
      res_q.dat    <= '0;
      res_q.zero   <= 1'b1;
      res_q.parity <= 1'b0;
    end else if (accept) begin
      vld_q <= 1'b1;
      res_q <= res_d;
    end else if (out_ready) begin
      // Drain without replacement: data and flags keep their last value.
      vld_q <= 1'b0;
    end
  end

  // Accumulate takes priority over clear; when both, the op already used ACC_INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= ACC_INIT;
    end else if (accept && in_acc) begin
      acc_q <= result;
    end else if (acc_clr) begin
      acc_q <= ACC_INIT;
    end
  end

  assign out_valid  = vld_q;
  assign out_data   = res_q.dat;
  assign out_zero   = res_q.zero;
  assign out_parity = res_q.parity;
  assign acc_value  = acc_q;

endmodule
